id_decode_queue: RTL and testbench

- Parametrised successor of the decode stage: an IF→ID decoupling instruction queue of DEPTH entries, feeding a registered ID/EX output slot.
- The head entry is decoded for immediate, branch target and branch condition, using operands forwarded from NUM_FWD generalised bypass sources with load-use stall detection.
- The register file is external; this block drives its read addresses and consumes its read data.
- Sits between the fetch stage and the execute-stage pipeline register. Flushes on redirect or exception.

---
 rtl/id_pkg.sv | 24 ++
 rtl/id_decode_queue_if.sv | 32 +++
 rtl/id_fwd_mux.sv | 36 +++
 rtl/id_decode_queue.sv | 194 +++++++++++++++++++
 tb/tb_id_decode_queue.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// Decode constants and the instruction-queue entry type shared by the ID stage.
package id_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } q_entry_t;

  // Logical immediates (opcode bits [29:28] == 11) are zero-extended.
  function automatic logic [31:0] ext_imm(input logic [1:0] sel, input logic [15:0] imm);
    if (sel == 2'b11) return {16'h0000, imm};
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_decode_queue_if.sv
// Fetch-side push channel and execute-side decoded-instruction channel of the ID queue.
interface id_decode_queue_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [31:0]     in_pc4;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [31:0]     out_pc4;
  logic [XLEN-1:0] out_rdata1;
  logic [XLEN-1:0] out_rdata2;
  logic [31:0]     out_sign_imm;
  logic [31:0]     out_branch_addr;
  logic            out_is_branch;
  logic            out_branch_taken;

  modport master (
    output in_valid, in_instr, in_pc4, out_ready,
    input  in_ready, out_valid, out_instr, out_pc4, out_rdata1, out_rdata2,
           out_sign_imm, out_branch_addr, out_is_branch, out_branch_taken
  );

  modport slave (
    input  in_valid, in_instr, in_pc4, out_ready,
    output in_ready, out_valid, out_instr, out_pc4, out_rdata1, out_rdata2,
           out_sign_imm, out_branch_addr, out_is_branch, out_branch_taken
  );

endinterface

// File: rtl/id_fwd_mux.sv
// Priority bypass for one source operand; index 0 is the youngest source and wins.
// pending_o flags that the winning source has not produced its result yet.
module id_fwd_mux #(
  parameter int NUM_FWD = 3,
  parameter int XLEN    = 32
) (
  input  logic [4:0]            raddr_i,
  input  logic [XLEN-1:0]       rf_rdata_i,
  input  logic [NUM_FWD-1:0]    fwd_we_i,
  input  logic [NUM_FWD-1:0]    fwd_pending_i,
  input  logic [NUM_FWD*5-1:0]  fwd_waddr_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  pending_o
);

  logic w_hit;

  always_comb begin
    data_o    = rf_rdata_i;
    pending_o = 1'b0;
    w_hit     = 1'b0;
    if (raddr_i == 5'd0) begin
      data_o = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!w_hit && fwd_we_i[i] && (fwd_waddr_i[i*5 +: 5] == raddr_i)) begin
          w_hit     = 1'b1;
          data_o    = fwd_wdata_i[i*XLEN +: XLEN];
          pending_o = fwd_pending_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_decode_queue.sv
// IF->ID instruction queue whose head is decoded (operands, immediate, branch) into a registered ID/EX slot.
// Push lands at the head one cycle later; issue is held off by a load-use hazard or a full, unaccepted slot.
module id_decode_queue
  import id_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  id_decode_queue_if.slave          bus,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD-1:0]        fwd_pending_i,
  input  logic [NUM_FWD*5-1:0]      fwd_waddr_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_wdata_i,
  output logic [4:0]                rf_raddr1_o,
  output logic [4:0]                rf_raddr2_o,
  input  logic [XLEN-1:0]           rf_rdata1_i,
  input  logic [XLEN-1:0]           rf_rdata2_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  q_entry_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_instr;
  logic [31:0]     r_out_pc4;
  logic [XLEN-1:0] r_out_rdata1;
  logic [XLEN-1:0] r_out_rdata2;
  logic [31:0]     r_out_sign_imm;
  logic [31:0]     r_out_branch_addr;
  logic            r_out_is_branch;
  logic            r_out_branch_taken;

  q_entry_t        w_head;
  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_pend_a;
  logic            w_pend_b;
  logic            w_hazard;
  logic [31:0]     w_imm;
  logic [31:0]     w_baddr;
  logic            w_is_br;
  logic            w_taken;
  logic            w_full;
  logic            w_push;
  logic            w_issue;

  assign w_head      = r_mem[r_rptr];
  assign w_op        = w_head.instr[31:26];
  assign w_rs        = w_head.instr[25:21];
  assign w_rt        = w_head.instr[20:16];
  assign rf_raddr1_o = w_rs;
  assign rf_raddr2_o = w_rt;

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_a (
    .raddr_i       (w_rs),
    .rf_rdata_i    (rf_rdata1_i),
    .fwd_we_i      (fwd_we_i),
    .fwd_pending_i (fwd_pending_i),
    .fwd_waddr_i   (fwd_waddr_i),
    .fwd_wdata_i   (fwd_wdata_i),
    .data_o        (w_a),
    .pending_o     (w_pend_a)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_b (
    .raddr_i       (w_rt),
    .rf_rdata_i    (rf_rdata2_i),
    .fwd_we_i      (fwd_we_i),
    .fwd_pending_i (fwd_pending_i),
    .fwd_waddr_i   (fwd_waddr_i),
    .fwd_wdata_i   (fwd_wdata_i),
    .data_o        (w_b),
    .pending_o     (w_pend_b)
  );

  // Both operands count as used, so a pending rt stalls even an I-type head.
  assign w_hazard = w_pend_a | w_pend_b;

  assign w_imm   = ext_imm(w_head.instr[29:28], w_head.instr[15:0]);
  assign w_baddr = w_head.pc4 + {w_imm[29:0], 2'b00};

  always_comb begin
    w_is_br = 1'b0;
    w_taken = 1'b0;
    case (w_op)
      OP_BEQ: begin
        w_is_br = 1'b1;
        w_taken = (w_a == w_b);
      end
      OP_BNE: begin
        w_is_br = 1'b1;
        w_taken = (w_a != w_b);
      end
      OP_BLEZ: begin
        w_is_br = 1'b1;
        w_taken = w_a[XLEN-1] || (w_a == '0);
      end
      OP_BGTZ: begin
        w_is_br = 1'b1;
        w_taken = !w_a[XLEN-1] && (w_a != '0);
      end
      OP_REGIMM: begin
        if (w_rt == RT_BLTZ) begin
          w_is_br = 1'b1;
          w_taken = w_a[XLEN-1];
        end else if (w_rt == RT_BGEZ) begin
          w_is_br = 1'b1;
          w_taken = !w_a[XLEN-1];
        end
      end
      default: ;
    endcase
  end

  // Ready is derived from occupancy alone; a same-cycle pop does not free a slot.
  assign w_full       = (r_count == CW'(DEPTH));
  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid && !w_full && !flush_i;
  assign w_issue      = (r_count != '0) && !w_hazard &&
                        (!r_out_valid || bus.out_ready) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{instr: bus.in_instr[31:0], pc4: bus.in_pc4};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_issue) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_issue);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out_valid        <= 1'b0;
      r_out_instr        <= '0;
      r_out_pc4          <= '0;
      r_out_rdata1       <= '0;
      r_out_rdata2       <= '0;
      r_out_sign_imm     <= '0;
      r_out_branch_addr  <= '0;
      r_out_is_branch    <= 1'b0;
      r_out_branch_taken <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid        <= 1'b1;
      r_out_instr        <= XLEN'(w_head.instr);
      r_out_pc4          <= w_head.pc4;
      r_out_rdata1       <= w_a;
      r_out_rdata2       <= w_b;
      r_out_sign_imm     <= w_imm;
      r_out_branch_addr  <= w_baddr;
      r_out_is_branch    <= w_is_br;
      r_out_branch_taken <= w_taken;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid        = r_out_valid;
  assign bus.out_instr        = r_out_instr;
  assign bus.out_pc4          = r_out_pc4;
  assign bus.out_rdata1       = r_out_rdata1;
  assign bus.out_rdata2       = r_out_rdata2;
  assign bus.out_sign_imm     = r_out_sign_imm;
  assign bus.out_branch_addr  = r_out_branch_addr;
  assign bus.out_is_branch    = r_out_is_branch;
  assign bus.out_branch_taken = r_out_branch_taken;
  assign count_o              = r_count;

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed corner cases, then randomized traffic against a queue-based scoreboard.
module tb_id_decode_queue;
  import id_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int NF    = 3;

  typedef struct packed {
    logic [31:0] instr, pc4, r1, r2, imm, ba;
    logic        isb, tk;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic flush_i = 1'b0;
  always #5 clk_i = ~clk_i;

  id_decode_queue_if #(.XLEN(XLEN)) bus();

  logic [NF-1:0]      fwd_we, fwd_pend;
  logic [NF*5-1:0]    fwd_waddr;
  logic [NF*XLEN-1:0] fwd_wdata;
  logic [4:0]         rf_raddr1, rf_raddr2;
  logic [31:0]        rf_rdata1, rf_rdata2;
  logic [2:0]         count;

  logic [31:0] rf_mem [32];
  logic        f_we [NF];
  logic        f_pend [NF];
  logic [4:0]  f_addr [NF];
  logic [31:0] f_data [NF];

  int   nvec = 0;
  int   nerr = 0;
  bit   sb_on = 1'b0;
  exp_t exp_q [$];

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  always_comb begin
    fwd_we    = '0;
    fwd_pend  = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    for (int i = 0; i < NF; i++) begin
      fwd_we[i]             = f_we[i];
      fwd_pend[i]           = f_pend[i];
      fwd_waddr[i*5 +: 5]   = f_addr[i];
      fwd_wdata[i*32 +: 32] = f_data[i];
    end
  end

  id_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_FWD(NF)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .bus           (bus),
    .fwd_we_i      (fwd_we),
    .fwd_pending_i (fwd_pend),
    .fwd_waddr_i   (fwd_waddr),
    .fwd_wdata_i   (fwd_wdata),
    .rf_raddr1_o   (rf_raddr1),
    .rf_raddr2_o   (rf_raddr2),
    .rf_rdata1_i   (rf_rdata1),
    .rf_rdata2_i   (rf_rdata2),
    .count_o       (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clr_fwd();
    for (int i = 0; i < NF; i++) begin
      f_we[i] = 1'b0; f_pend[i] = 1'b0; f_addr[i] = 5'd0; f_data[i] = 32'd0;
    end
  endtask

  task automatic set_fwd(input int i, input logic we, input logic pend,
                         input logic [4:0] a, input logic [31:0] d);
    f_we[i] = we; f_pend[i] = pend; f_addr[i] = a; f_data[i] = d;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [31:0] p4);
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc4 = p4;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  // Reference: operand value as the architectural bypass rule defines it.
  function automatic logic [31:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < NF; i++)
      if (f_we[i] && f_addr[i] == a) return f_data[i];
    return rf_mem[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p4);
    exp_t e;
    logic [5:0] op;
    logic [4:0] rt;
    logic signed [31:0] a, b;
    op = ins[31:26];
    rt = ins[20:16];
    a = opnd(ins[25:21]);
    b = opnd(rt);
    e.instr = ins;
    e.pc4   = p4;
    e.r1    = a;
    e.r2    = b;
    if (ins[29:28] == 2'b11) e.imm = 32'(ins[15:0]);
    else                     e.imm = 32'($signed(ins[15:0]));
    e.ba  = p4 + e.imm * 32'd4;
    e.isb = 1'b1;
    e.tk  = 1'b0;
    case (op)
      6'd4: e.tk = (a == b);
      6'd5: e.tk = (a != b);
      6'd6: e.tk = (a <= 0);
      6'd7: e.tk = (a > 0);
      6'd1: begin
        if (rt == 5'd0)      e.tk = (a < 0);
        else if (rt == 5'd1) e.tk = (a >= 0);
        else                 e.isb = 1'b0;
      end
      default: e.isb = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [4:0] rt;
    case ($urandom_range(0, 9))
      0: op = OP_BEQ;
      1: op = OP_BNE;
      2: op = OP_BLEZ;
      3: op = OP_BGTZ;
      4, 5: op = OP_REGIMM;
      6: op = 6'h00;
      7: op = 6'h0D;
      8: op = 6'h0C;
      default: op = 6'h23;
    endcase
    rt = (op == OP_REGIMM) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 7));
    return mk(op, 5'($urandom_range(0, 7)), rt, 16'($urandom));
  endfunction

  // Scoreboard monitor: compares every accepted output against the oldest expectation.
  always @(negedge clk_i) begin
    if (sb_on && rst_i) begin
      if (bus.out_valid && bus.out_ready) begin
        exp_t act, e;
        act = '{instr: bus.out_instr, pc4: bus.out_pc4, r1: bus.out_rdata1, r2: bus.out_rdata2,
                imm: bus.out_sign_imm, ba: bus.out_branch_addr, isb: bus.out_is_branch,
                tk: bus.out_branch_taken};
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL sb_unexpected: got instr=%h with no expected item", act.instr);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            nerr++;
            $display("FAIL sb_item: got instr=%h pc4=%h r1=%h r2=%h imm=%h ba=%h br=%b tk=%b want instr=%h pc4=%h r1=%h r2=%h imm=%h ba=%h br=%b tk=%b",
                     act.instr, act.pc4, act.r1, act.r2, act.imm, act.ba, act.isb, act.tk,
                     e.instr, e.pc4, e.r1, e.r2, e.imm, e.ba, e.isb, e.tk);
          end
        end
      end
      if (flush_i) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_instr, bus.in_pc4));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] t1 [6];
    int k;
    int n;
    bit acc;

    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc4 = '0; bus.out_ready = 1'b0;
    clr_fwd();
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int j = 0; j < 6; j++) t1[j] = mk(6'h00, 5'(j + 10), 5'(j + 11), 16'(j));

    // Reset state
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_rdata1", bus.out_rdata1, 32'd0);
    check("rst_out_sign_imm", bus.out_sign_imm, 32'd0);
    check("rst_out_baddr", bus.out_branch_addr, 32'd0);
    check("rst_out_taken", 32'(bus.out_branch_taken), 32'd0);
    rst_i = 1'b1;
    tick();

    // Fill with a stalled consumer: one in the slot, DEPTH queued
    bus.in_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_instr = t1[k];
      bus.in_pc4   = 32'h100 + 32'(k) * 4;
      acc = bus.in_ready;
      tick();
      if (acc) k++;
    end
    check("fill_accepted", 32'(k), 32'd5);
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill_out_valid", 32'(bus.out_valid), 32'd1);
    check("fill_out_instr", bus.out_instr, t1[0]);
    bus.out_ready = 1'b1;
    acc = bus.in_ready;
    tick();
    if (acc) k++;
    check("pop_count", 32'(count), 32'd3);
    check("pop_out_instr", bus.out_instr, t1[1]);
    acc = bus.in_ready;
    tick();
    if (acc) k++;
    check("sixth_accepted", 32'(k), 32'd6);
    check("sixth_count", 32'(count), 32'd3);
    check("order_2", bus.out_instr, t1[2]);
    bus.in_valid = 1'b0;
    for (int j = 3; j < 6; j++) begin
      tick();
      check("order_n", bus.out_instr, t1[j]);
    end
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Forwarding priority
    rf_mem[8] = 32'h99;
    set_fwd(0, 1'b1, 1'b0, 5'd8, 32'h11);
    set_fwd(2, 1'b1, 1'b0, 5'd8, 32'h33);
    push_one(mk(6'h00, 5'd8, 5'd0, 16'h20), 32'h200);
    check("fwd_prio_valid", 32'(bus.out_valid), 32'd1);
    check("fwd_prio_src0", bus.out_rdata1, 32'h11);
    check("fwd_rt_zero", bus.out_rdata2, 32'd0);
    f_we[0] = 1'b0;
    push_one(mk(6'h00, 5'd8, 5'd0, 16'h20), 32'h204);
    check("fwd_src2", bus.out_rdata1, 32'h33);
    clr_fwd();
    push_one(mk(6'h00, 5'd8, 5'd0, 16'h20), 32'h208);
    check("fwd_rf", bus.out_rdata1, 32'h99);

    // r0 is never forwarded and never stalls
    set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    push_one(mk(6'h00, 5'd0, 5'd0, 16'h0), 32'h20C);
    check("r0_no_stall", 32'(bus.out_valid), 32'd1);
    check("r0_zero", bus.out_rdata1, 32'd0);

    // Load-use stall on rt
    clr_fwd();
    rf_mem[3] = 32'h3333;
    rf_mem[9] = 32'hAAAA;
    set_fwd(1, 1'b1, 1'b1, 5'd9, 32'h0);
    bus.in_valid = 1'b1; bus.in_instr = mk(6'h00, 5'd3, 5'd9, 16'h0); bus.in_pc4 = 32'h300;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("stall_count", 32'(count), 32'd1);
    f_pend[1] = 1'b0;
    f_data[1] = 32'h55;
    tick();
    check("unstall_valid", 32'(bus.out_valid), 32'd1);
    check("unstall_rdata2", bus.out_rdata2, 32'h55);
    check("unstall_rdata1", bus.out_rdata1, 32'h3333);

    // Branches and immediates
    clr_fwd();
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd5;
    push_one(mk(OP_BEQ, 5'd1, 5'd2, 16'hFFFF), 32'h1000);
    check("beq_is_branch", 32'(bus.out_is_branch), 32'd1);
    check("beq_taken", 32'(bus.out_branch_taken), 32'd1);
    check("beq_baddr", bus.out_branch_addr, 32'h0FFC);
    check("beq_imm", bus.out_sign_imm, 32'hFFFF_FFFF);
    rf_mem[1] = 32'h8000_0000;
    push_one(mk(OP_BGTZ, 5'd1, 5'd0, 16'h0004), 32'h2000);
    check("bgtz_is_branch", 32'(bus.out_is_branch), 32'd1);
    check("bgtz_taken", 32'(bus.out_branch_taken), 32'd0);
    check("bgtz_baddr", bus.out_branch_addr, 32'h2010);
    push_one(mk(OP_REGIMM, 5'd1, RT_BLTZ, 16'h0001), 32'h2100);
    check("bltz_taken", 32'(bus.out_branch_taken), 32'd1);
    push_one(mk(6'h0D, 5'd1, 5'd2, 16'h8000), 32'h3000);
    check("ori_imm", bus.out_sign_imm, 32'h0000_8000);
    check("ori_not_branch", 32'(bus.out_is_branch), 32'd0);

    // Flush with a full queue and a live slot
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in_instr = mk(6'h00, 5'd4, 5'd5, 16'(c)); bus.in_pc4 = 32'h400 + 32'(c) * 4;
      tick();
    end
    check("pre_flush_count", 32'(count), 32'd4);
    check("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    flush_i = 1'b1;
    bus.in_instr = 32'hDEAD_BEEF;
    tick();
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    flush_i = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_push_dropped", 32'(count), 32'd0);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check("flush_never_issued", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-push
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = mk(6'h0D, 5'd6, 5'd7, 16'h1234);
    bus.in_pc4 = 32'h500;
    tick(); tick(); tick();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_instr", bus.out_instr, 32'd0);
    check("arst_out_pc4", bus.out_pc4, 32'd0);
    check("arst_out_imm", bus.out_sign_imm, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // Randomized traffic against the scoreboard
    sb_on = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NF; i++)
        set_fwd(i, 1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 7)), pick());
      for (int a = 1; a < 32; a++) rf_mem[a] = pick();
      for (int c = 0; c < 120; c++) begin
        flush_i       = ($urandom_range(0, 39) == 0);
        bus.in_valid  = ($urandom_range(0, 9) < 7);
        bus.in_instr  = rand_instr();
        bus.in_pc4    = $urandom & 32'hFFFF_FFFC;
        bus.out_ready = flush_i ? 1'b0 : ($urandom_range(0, 9) < 6);
        tick();
      end
      flush_i = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while ((bus.out_valid || count != 3'd0) && n < 40) begin
        tick();
        n++;
      end
      check("rand_drain_valid", 32'(bus.out_valid), 32'd0);
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    end
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
